// File: rtl/noc_pkg.sv
// noc_pkg: shared mesh NoC definitions.
//   dir_e       - one-hot output direction, ordered {N,E,W,S,L} from MSB to LSB
//   flit_w      - flit width for a given dest-ID width and payload width
//   flit_valid  - extract the valid bit (MSB) of a flit
//   flit_dest   - extract the destination router ID field
//   flit_payload- extract the payload field
// Flit layout: {valid, dest[ID_W-1:0], payload[DATA_W-1:0]}.
// Extraction functions take the flit zero-extended to MAX_FLIT_W bits so a
// single definition serves every parameterisation; callers cast the result.
package noc_pkg;

    typedef enum logic [4:0] {
        DIR_N = 5'b10000,
        DIR_E = 5'b01000,
        DIR_W = 5'b00100,
        DIR_S = 5'b00010,
        DIR_L = 5'b00001
    } dir_e;

    localparam int MAX_FLIT_W = 64;

    function automatic int flit_w(input int id_w, input int data_w);
        return 1 + id_w + data_w;
    endfunction

    function automatic logic flit_valid(input logic [MAX_FLIT_W-1:0] flit,
                                        input int                    fw);
        return flit[fw-1];
    endfunction

    function automatic logic [MAX_FLIT_W-1:0] flit_dest(
        input logic [MAX_FLIT_W-1:0] flit,
        input int                    id_w,
        input int                    data_w
    );
        logic [MAX_FLIT_W-1:0] mask;
        mask = (MAX_FLIT_W'(1) << id_w) - MAX_FLIT_W'(1);
        return (flit >> data_w) & mask;
    endfunction

    function automatic logic [MAX_FLIT_W-1:0] flit_payload(
        input logic [MAX_FLIT_W-1:0] flit,
        input int                    data_w
    );
        logic [MAX_FLIT_W-1:0] mask;
        mask = (MAX_FLIT_W'(1) << data_w) - MAX_FLIT_W'(1);
        return flit & mask;
    endfunction

endpackage

// File: rtl/xy_route_calc.sv
// xy_route_calc: combinational dimension-ordered (X then Y) route decision.
//   dest    - destination router ID of the flit
//   own_id  - ID of the router making the decision
//   route   - one-hot {N,E,W,S,L}; all zero when dest is illegal
//   illegal - dest does not name a router in this mesh
// IDs are y*MESH_X + x with row 0 on the north edge, so a smaller y is north.
module xy_route_calc
    import noc_pkg::*;
#(
    parameter int MESH_X = 4,
    parameter int MESH_Y = 4,
    parameter int ID_W   = 4
) (
    input  logic [ID_W-1:0] dest,
    input  logic [ID_W-1:0] own_id,
    output logic [4:0]      route,
    output logic            illegal
);

    localparam int unsigned MX    = MESH_X;
    localparam int unsigned NODES = MESH_X * MESH_Y;

    int unsigned d, o, dx, dy, ox, oy;

    always_comb begin
        d       = 32'(dest);
        o       = 32'(own_id);
        dx      = d % MX;
        dy      = d / MX;
        ox      = o % MX;
        oy      = o / MX;
        illegal = (d >= NODES);
        route   = '0;
        if (!illegal) begin
            if (dx > ox)      route = DIR_E;
            else if (dx < ox) route = DIR_W;
            else if (dy < oy) route = DIR_N;
            else if (dy > oy) route = DIR_S;
            else              route = DIR_L;
        end
    end

endmodule

// File: rtl/mesh_input_port.sv
// mesh_input_port: buffered input port of a 2D-mesh XY router.
//   clk, rst     - clock; asynchronous active-high reset
//   flit_i       - incoming flit {valid, dest, payload}
//   grant_i      - crossbar grant, pops the head flit when it has a route
//   head_flit_o  - head entry (valid bit 0 when empty)
//   route_req_o  - one-hot {N,E,W,S,L} request for the head flit
//   consume_o    - registered pulse per flit removed (popped or dropped)
//   full_o       - buffer holds DEPTH flits
//   count_o      - occupancy
//   drop_cnt_o   - saturating count of flits dropped for an illegal dest
//   overflow_o   - sticky: a flit arrived while full with nothing leaving
//
// Handshake: flit_i carries its own valid bit and there is no ready back to
// the sender. The sender is expected to track buffer space from consume_o
// (one pulse per freed slot, one cycle after the slot frees); a flit that
// arrives with no space is lost and flagged on overflow_o. On the crossbar
// side route_req_o acts as valid and grant_i as ready: the head leaves in a
// cycle where both are set, and a grant with no request is ignored.
module mesh_input_port
    import noc_pkg::*;
#(
    parameter  int MESH_X    = 4,
    parameter  int MESH_Y    = 4,
    parameter  int ROUTER_ID = 0,
    parameter  int DATA_W    = 12,
    parameter  int DEPTH     = 4,
    localparam int ID_W      = $clog2(MESH_X * MESH_Y),
    localparam int FLIT_W    = flit_w(ID_W, DATA_W),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              grant_i,
    output logic [FLIT_W-1:0] head_flit_o,
    output logic [4:0]        route_req_o,
    output logic              consume_o,
    output logic              full_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [7:0]        drop_cnt_o,
    output logic              overflow_o
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ID_W-1:0]  OWN_ID  = ID_W'(ROUTER_ID);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              consume_q;
    logic              overflow_q;
    logic [7:0]        drop_cnt;

    logic              head_valid;
    logic [ID_W-1:0]   head_dest;
    logic [4:0]        route_raw;
    logic              dest_illegal;
    logic              in_valid, pop, drop, remove, push, overflow_evt;

    // Head is read straight from storage: a flit written this cycle shows up
    // next cycle, never combinationally from flit_i.
    assign head_valid  = (count != '0);
    assign head_flit_o = head_valid ? mem[rd_ptr] : '0;
    assign head_dest   = ID_W'(flit_dest(MAX_FLIT_W'(head_flit_o), ID_W, DATA_W));

    xy_route_calc #(
        .MESH_X (MESH_X),
        .MESH_Y (MESH_Y),
        .ID_W   (ID_W)
    ) u_route (
        .dest    (head_dest),
        .own_id  (OWN_ID),
        .route   (route_raw),
        .illegal (dest_illegal)
    );

    assign route_req_o = head_valid ? route_raw : '0;

    assign in_valid = flit_valid(MAX_FLIT_W'(flit_i), FLIT_W);
    assign pop      = grant_i & (route_req_o != '0);
    // An illegal head never requests, so it is removed here without a grant.
    assign drop     = head_valid & dest_illegal;
    assign remove   = pop | drop;
    // A slot freed this cycle may be refilled this cycle, even when full.
    assign push         = in_valid & ((count != DEPTH_C) | remove);
    assign overflow_evt = in_valid & (count == DEPTH_C) & ~remove;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            consume_q  <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
            if (remove) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, remove})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            consume_q <= remove;
            if (overflow_evt) overflow_q <= 1'b1;
            if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Storage has no reset; entries are only observable once written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= flit_i;
    end

    assign consume_o  = consume_q;
    assign full_o     = (count == DEPTH_C);
    assign count_o    = count;
    assign drop_cnt_o = drop_cnt;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_mesh_input_port.sv
module tb_mesh_input_port;

    localparam logic [4:0] R_N = 5'b10000;
    localparam logic [4:0] R_E = 5'b01000;
    localparam logic [4:0] R_W = 5'b00100;
    localparam logic [4:0] R_S = 5'b00010;
    localparam logic [4:0] R_L = 5'b00001;
    localparam logic [4:0] R_0 = 5'b00000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // DUT a: 4x4 mesh, router 5 (x=1, y=1), DEPTH 4
    logic [16:0] flit_a, head_a;
    logic        grant_a, consume_a, full_a, ovf_a;
    logic [4:0]  route_a;
    logic [2:0]  count_a;
    logic [7:0]  drop_a;

    // DUT b: 4 columns x 3 rows, router 5; IDs 12..15 are illegal
    logic [16:0] flit_b, head_b;
    logic        grant_b, consume_b, full_b, ovf_b;
    logic [4:0]  route_b;
    logic [2:0]  count_b;
    logic [7:0]  drop_b;

    mesh_input_port #(
        .MESH_X(4), .MESH_Y(4), .ROUTER_ID(5), .DATA_W(12), .DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .flit_i(flit_a), .grant_i(grant_a),
        .head_flit_o(head_a), .route_req_o(route_a), .consume_o(consume_a),
        .full_o(full_a), .count_o(count_a), .drop_cnt_o(drop_a),
        .overflow_o(ovf_a)
    );

    mesh_input_port #(
        .MESH_X(4), .MESH_Y(3), .ROUTER_ID(5), .DATA_W(12), .DEPTH(4)
    ) dut_b (
        .clk(clk), .rst(rst), .flit_i(flit_b), .grant_i(grant_b),
        .head_flit_o(head_b), .route_req_o(route_b), .consume_o(consume_b),
        .full_o(full_b), .count_o(count_b), .drop_cnt_o(drop_b),
        .overflow_o(ovf_b)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors sampled on the falling edge, one sample per cycle.
    int   cons_a_cnt   = 0;
    int   cons_b_cnt   = 0;
    logic route_b_seen = 1'b0;
    always @(negedge clk) begin
        if (consume_a === 1'b1) cons_a_cnt++;
        if (consume_b === 1'b1) cons_b_cnt++;
        if (route_b !== 5'b0) route_b_seen = 1'b1;
    end

    // ---------------- driver helpers ----------------
    function automatic logic [16:0] mk(input logic [3:0] dest, input logic [11:0] pay);
        return {1'b1, dest, pay};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic [3:0]  dest;
        logic [11:0] pay;
        logic        grant;
        logic [2:0]  e_count;
        logic [4:0]  e_route;
        logic        e_hv;
        logic [16:0] e_head;
        logic        e_consume;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    initial begin
        vecs[0] = '{1'b1, 4'd7,  12'h0A1, 1'b0, 3'd1, R_E, 1'b1, mk(4'd7,  12'h0A1), 1'b0};
        vecs[1] = '{1'b0, 4'd0,  12'h000, 1'b1, 3'd0, R_0, 1'b0, 17'h0,              1'b1};
        vecs[2] = '{1'b0, 4'd0,  12'h000, 1'b0, 3'd0, R_0, 1'b0, 17'h0,              1'b0};
        vecs[3] = '{1'b1, 4'd1,  12'h111, 1'b0, 3'd1, R_N, 1'b1, mk(4'd1,  12'h111), 1'b0};
        vecs[4] = '{1'b1, 4'd13, 12'h222, 1'b1, 3'd1, R_S, 1'b1, mk(4'd13, 12'h222), 1'b1};
        vecs[5] = '{1'b1, 4'd4,  12'h333, 1'b1, 3'd1, R_W, 1'b1, mk(4'd4,  12'h333), 1'b1};
        vecs[6] = '{1'b1, 4'd5,  12'h444, 1'b1, 3'd1, R_L, 1'b1, mk(4'd5,  12'h444), 1'b1};
        vecs[7] = '{1'b0, 4'd0,  12'h000, 1'b1, 3'd0, R_0, 1'b0, 17'h0,              1'b1};
        vecs[8] = '{1'b0, 4'd0,  12'h000, 1'b1, 3'd0, R_0, 1'b0, 17'h0,              1'b0};

        rst     = 1'b1;
        flit_a  = '0;
        grant_a = 1'b0;
        flit_b  = '0;
        grant_b = 1'b0;
        @(negedge clk);

        // reset state
        check("rst count_a",   32'(count_a),   32'd0);
        check("rst head_a.v",  32'(head_a[16]), 32'd0);
        check("rst route_a",   32'(route_a),   32'd0);
        check("rst full_a",    32'(full_a),    32'd0);
        check("rst ovf_a",     32'(ovf_a),     32'd0);
        check("rst consume_a", 32'(consume_a), 32'd0);
        check("rst drop_a",    32'(drop_a),    32'd0);
        check("rst count_b",   32'(count_b),   32'd0);
        check("rst drop_b",    32'(drop_b),    32'd0);
        rst = 1'b0;

        // table-driven routing / pop / latency vectors
        for (int i = 0; i < NV; i++) begin
            flit_a  = vecs[i].v ? mk(vecs[i].dest, vecs[i].pay) : 17'h0;
            grant_a = vecs[i].grant;
            step();
            check($sformatf("vec%0d count", i),   32'(count_a),    32'(vecs[i].e_count));
            check($sformatf("vec%0d route", i),   32'(route_a),    32'(vecs[i].e_route));
            check($sformatf("vec%0d head.v", i),  32'(head_a[16]), 32'(vecs[i].e_hv));
            check($sformatf("vec%0d consume", i), 32'(consume_a),  32'(vecs[i].e_consume));
            check($sformatf("vec%0d full", i),    32'(full_a),     32'd0);
            if (vecs[i].e_hv)
                check($sformatf("vec%0d head", i), 32'(head_a), 32'(vecs[i].e_head));
        end
        flit_a  = '0;
        grant_a = 1'b0;

        // fill to full
        for (int p = 1; p <= 4; p++) begin
            flit_a = mk(4'd7, 12'(p));
            exp_q.push_back(flit_a);
            step();
        end
        flit_a = '0;
        check("fill count", 32'(count_a), 32'd4);
        check("fill full",  32'(full_a),  32'd1);
        check("fill ovf",   32'(ovf_a),   32'd0);
        check("fill head",  32'(head_a),  32'(exp_q[0]));

        // push and pop together while full
        flit_a  = mk(4'd7, 12'd6);
        grant_a = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(flit_a);
        step();
        check("full push+pop count", 32'(count_a),   32'd4);
        check("full push+pop ovf",   32'(ovf_a),     32'd0);
        check("full push+pop cons",  32'(consume_a), 32'd1);
        check("full push+pop head",  32'(head_a),    32'(exp_q[0]));

        // push while full without pop: flit is discarded
        flit_a  = mk(4'd7, 12'd5);
        grant_a = 1'b0;
        step();
        flit_a = '0;
        check("overflow flag",  32'(ovf_a),   32'd1);
        check("overflow count", 32'(count_a), 32'd4);
        check("overflow head",  32'(head_a),  32'(exp_q[0]));

        // drain and verify order and contents
        grant_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain head%0d", k), 32'(head_a), 32'(exp_q.pop_front()));
            step();
        end
        grant_a = 1'b0;
        check("drain count", 32'(count_a), 32'd0);
        check("drain full",  32'(full_a),  32'd0);
        check("drain ovf sticky", 32'(ovf_a), 32'd1);
        step();

        // reset mid-stream with 3 flits buffered
        for (int p = 0; p < 3; p++) begin
            flit_a = mk(4'd7, 12'(8'hA0 + p));
            step();
        end
        flit_a = '0;
        check("mid count before rst", 32'(count_a), 32'd3);
        cons_a_cnt = 0;
        grant_a    = 1'b1;
        rst        = 1'b1;
        #1;
        check("mid rst count",  32'(count_a),    32'd0);
        check("mid rst head.v", 32'(head_a[16]), 32'd0);
        check("mid rst route",  32'(route_a),    32'd0);
        check("mid rst full",   32'(full_a),     32'd0);
        check("mid rst ovf",    32'(ovf_a),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        step();
        grant_a = 1'b0;
        check("mid rst no consume", 32'(cons_a_cnt), 32'd0);
        check("mid rst count after", 32'(count_a), 32'd0);

        // DUT b: illegal destination auto-drop
        flit_b  = mk(4'd13, 12'h0AB);
        grant_b = 1'b1;
        step();
        flit_b = '0;
        check("drop head.v",   32'(head_b[16]), 32'd1);
        check("drop count1",   32'(count_b),    32'd1);
        check("drop route",    32'(route_b),    32'd0);
        check("drop cons0",    32'(consume_b),  32'd0);
        step();
        grant_b = 1'b0;
        check("drop count0",   32'(count_b),    32'd0);
        check("drop consume",  32'(consume_b),  32'd1);
        check("drop cnt1",     32'(drop_b),     32'd1);
        step();
        check("drop cons end", 32'(consume_b),  32'd0);

        // stream illegal flits up to 255 drops, then past saturation
        for (int i = 0; i < 254; i++) begin
            flit_b = mk(4'd14, 12'(i));
            step();
        end
        flit_b = '0;
        step(); step(); step();
        check("drop cnt 255",   32'(drop_b),     32'd255);
        check("cons pulses 255", 32'(cons_b_cnt), 32'd255);
        for (int i = 0; i < 45; i++) begin
            flit_b = mk(4'd13, 12'(i));
            step();
        end
        flit_b = '0;
        step(); step(); step();
        check("drop cnt sat",    32'(drop_b),       32'd255);
        check("cons pulses 300", 32'(cons_b_cnt),   32'd300);
        check("drop b count",    32'(count_b),      32'd0);
        check("drop b ovf",      32'(ovf_b),        32'd0);
        check("route b never",   32'(route_b_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
